// File: rtl/conv1d_engine.sv
// Streaming 1-D correlation: bias + dot(window, weights), saturated; P = ceil(FS/MM) MAC cycles per result.
// Latency P cycles from window-completing accept to valid_out; result held while ready_out is low, no input taken meanwhile.
module conv1d_engine #(
    parameter int DATA_WIDTH  = 12,
    parameter int FILTER_SIZE = 5,
    parameter int MAX_MULTS   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         conv1d_ready_in,
    input  logic                         conv1d_valid_in,
    input  logic signed [DATA_WIDTH-1:0] conv1d_data_in,
    input  logic signed [DATA_WIDTH-1:0] conv1d_weights [0:FILTER_SIZE-1],
    input  logic signed [DATA_WIDTH-1:0] conv1d_bias,
    input  logic                         conv1d_ready_out,
    output logic                         conv1d_valid_out,
    output logic signed [DATA_WIDTH-1:0] conv1d_data_out
);

    localparam int P      = (FILTER_SIZE + MAX_MULTS - 1) / MAX_MULTS;
    localparam int PAD    = P * MAX_MULTS;
    localparam int PW     = (P > 1) ? $clog2(P) : 1;
    localparam int CNT_W  = $clog2(FILTER_SIZE + 1);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(FILTER_SIZE) + 1;

    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   win_q [0:FILTER_SIZE-1];
    logic        [CNT_W-1:0]        fill_q;
    logic        [PW-1:0]           pass_q;
    logic signed [ACC_W-1:0]        acc_q;
    logic signed [DATA_WIDTH-1:0]   dout_q;

    logic                           accept;
    logic                           full_after;
    logic                           last_pass;
    logic signed [DATA_WIDTH-1:0]   w_pad [0:PAD-1];
    logic signed [DATA_WIDTH-1:0]   x_pad [0:PAD-1];
    logic signed [DATA_WIDTH-1:0]   a_op  [0:MAX_MULTS-1];
    logic signed [DATA_WIDTH-1:0]   b_op  [0:MAX_MULTS-1];
    logic signed [PROD_W-1:0]       prod  [0:MAX_MULTS-1];
    logic signed [ACC_W-1:0]        pass_sum;
    logic signed [ACC_W-1:0]        acc_sum;
    logic signed [ACC_W-1:0]        total;
    logic signed [DATA_WIDTH-1:0]   sat_val;

    assign accept     = (state_q == S_IDLE) && conv1d_valid_in;
    assign full_after = (fill_q >= CNT_W'(FILTER_SIZE - 1));
    assign last_pass  = (pass_q == PW'(P - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && full_after) state_d = S_MAC;
            S_MAC:   if (last_pass)            state_d = S_OUT;
            S_OUT:   if (conv1d_ready_out)     state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        conv1d_ready_in  = (state_q == S_IDLE);
        conv1d_valid_out = (state_q == S_OUT);
        conv1d_data_out  = dout_q;
    end

    // Taps past FILTER_SIZE-1 are zero-padded so the last pass can be partial.
    always_comb begin
        for (int i = 0; i < PAD; i++) begin
            w_pad[i] = '0;
            x_pad[i] = '0;
        end
        for (int i = 0; i < FILTER_SIZE; i++) begin
            w_pad[i] = conv1d_weights[i];
            x_pad[i] = win_q[i];
        end
    end

    always_comb begin
        pass_sum = '0;
        for (int m = 0; m < MAX_MULTS; m++) begin
            a_op[m] = '0;
            b_op[m] = '0;
            for (int p = 0; p < P; p++) begin
                if (pass_q == PW'(p)) begin
                    a_op[m] = w_pad[p*MAX_MULTS + m];
                    b_op[m] = x_pad[p*MAX_MULTS + m];
                end
            end
            prod[m]  = PROD_W'(a_op[m]) * PROD_W'(b_op[m]);
            pass_sum = pass_sum + ACC_W'(prod[m]);
        end
        acc_sum = acc_q + pass_sum;
        total   = acc_sum + ACC_W'(conv1d_bias);
        if (total > MAXV)      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (total < MINV) sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                   sat_val = total[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FILTER_SIZE; i++) win_q[i] <= '0;
            fill_q <= '0;
            pass_q <= '0;
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < FILTER_SIZE - 1; i++) win_q[i] <= win_q[i+1];
                win_q[FILTER_SIZE-1] <= conv1d_data_in;
                fill_q <= full_after ? CNT_W'(FILTER_SIZE) : fill_q + CNT_W'(1);
                if (full_after) begin
                    acc_q  <= '0;
                    pass_q <= '0;
                end
            end
            if (state_q == S_MAC) begin
                acc_q  <= acc_sum;
                pass_q <= pass_q + PW'(1);
                if (last_pass) dout_q <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_engine.sv
// Directed bench for conv1d_engine: one instance with full-width MAC, one time-shared (MAX_MULTS=2).
module tb_conv1d_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               vin;
    logic signed [11:0] din;
    logic signed [11:0] w [0:4];
    logic signed [11:0] bias;
    logic               rout;
    logic               rin1, vout1, rin2, vout2;
    logic        [11:0] dout1, dout2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv1d_engine #(.DATA_WIDTH(12), .FILTER_SIZE(5), .MAX_MULTS(5)) dut (
        .clk(clk), .rst(rst),
        .conv1d_ready_in(rin1), .conv1d_valid_in(vin), .conv1d_data_in(din),
        .conv1d_weights(w), .conv1d_bias(bias),
        .conv1d_ready_out(rout), .conv1d_valid_out(vout1), .conv1d_data_out(dout1)
    );

    conv1d_engine #(.DATA_WIDTH(12), .FILTER_SIZE(5), .MAX_MULTS(2)) dut2 (
        .clk(clk), .rst(rst),
        .conv1d_ready_in(rin2), .conv1d_valid_in(vin), .conv1d_data_in(din),
        .conv1d_weights(w), .conv1d_bias(bias),
        .conv1d_ready_out(rout), .conv1d_valid_out(vout2), .conv1d_data_out(dout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int s);
        return (s == 2) ? rin2 : rin1;
    endfunction

    function automatic logic vld_of(input int s);
        return (s == 2) ? vout2 : vout1;
    endfunction

    function automatic logic [11:0] dat_of(input int s);
        return (s == 2) ? dout2 : dout1;
    endfunction

    task automatic set_w(input logic signed [11:0] a, b, c, d, e);
        w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
    endtask

    task automatic do_reset();
        @(negedge clk);
        vin = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Presents one sample to instance s; returns 1ns after the accepting edge.
    task automatic send(input int s, input logic signed [11:0] x);
        int n = 0;
        @(negedge clk);
        while (!rdy_of(s) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        vin = 1'b1;
        din = x;
        @(posedge clk);
        #1 vin = 1'b0;
    endtask

    task automatic expect_out(input int s, input string tag, input logic [11:0] exp, input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld_of(s) && n < 20);
        check({tag, "_vld"}, vld_of(s), 1);
        if (vld_of(s)) begin
            check({tag, "_lat"}, n - 1, lat);
            check({tag, "_dat"}, dat_of(s), exp);
        end
    endtask

    task automatic expect_none(input int s, input string tag, input int cycles);
        logic seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (vld_of(s)) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b0;
        vin  = 1'b0;
        din  = '0;
        bias = '0;
        rout = 1'b1;
        set_w(1, 1, 1, 1, 1);
        #12;
        check("rst_rdy",   rin1,  1);
        check("rst_vld",   vout1, 0);
        check("rst_dat",   dout1, 0);
        check("rst_rdy2",  rin2,  1);
        check("rst_vld2",  vout2, 0);
        @(negedge clk);
        rst = 1'b1;

        // Fill and steady state
        for (int k = 0; k < 4; k++) begin
            send(1, 1);
            expect_none(1, "fill_novld", 2);
        end
        send(1, 1);
        expect_out(1, "fill5", 12'd5, 1);
        for (int k = 0; k < 3; k++) begin
            send(1, 1);
            expect_out(1, "steady", 12'd5, 1);
        end

        // Tap ordering: weights[0] meets the oldest sample
        do_reset();
        set_w(1, 2, 3, 4, 5);
        bias = 12'sd3;
        for (int k = 1; k <= 4; k++) send(1, 12'(k));
        send(1, 5);
        expect_out(1, "order58", 12'd58, 1);
        send(1, 6);
        expect_out(1, "order73", 12'd73, 1);

        // Saturation
        do_reset();
        set_w(2047, 2047, 2047, 2047, 2047);
        bias = '0;
        for (int k = 0; k < 5; k++) send(1, 2047);
        expect_out(1, "sat_pos", 12'h7FF, 1);
        do_reset();
        set_w(-2048, -2048, -2048, -2048, -2048);
        for (int k = 0; k < 5; k++) send(1, 2047);
        expect_out(1, "sat_neg", 12'h800, 1);
        do_reset();
        set_w(1, 1, 1, 1, 1);
        bias = -12'sd10;
        for (int k = 0; k < 5; k++) send(1, 1);
        expect_out(1, "neg_bias", 12'hFFB, 1);

        // Backpressure
        do_reset();
        bias = '0;
        rout = 1'b0;
        for (int k = 0; k < 5; k++) send(1, 1);
        expect_out(1, "bp", 12'd5, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_vld", vout1, 1);
            check("bp_hold_dat", dout1, 12'd5);
            check("bp_hold_rdy", rin1,  0);
        end
        rout = 1'b1;
        @(negedge clk);
        check("bp_release_vld", vout1, 0);
        check("bp_release_rdy", rin1,  1);

        // Time-shared multipliers, P = 3
        do_reset();
        for (int k = 0; k < 4; k++) send(2, 1);
        send(2, 1);
        expect_out(2, "mm2", 12'd5, 3);

        // Reset during MAC flushes the window
        do_reset();
        for (int k = 0; k < 5; k++) send(2, 1);
        rst = 1'b0;
        #1;
        check("midmac_rdy", rin2,  1);
        check("midmac_vld", vout2, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(2, 1);
            expect_none(2, "midmac_refill", 6);
        end
        send(2, 1);
        expect_out(2, "midmac_first", 12'd5, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
